hist_readout: RTL

HIST_READOUT -- requirements
Module: hist_readout

---
 rtl/hist_readout_pkg.sv | 22 ++
 rtl/hist_frame_ser.sv | 54 +++++
 rtl/hist_readout.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/hist_readout_pkg.sv
// Shared definitions for the histogram readout path and its counter.
package hist_readout_pkg;

    // Readout FSM states, in frame order
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        FLAG = 3'd2,
        LEN  = 3'd3,
        DATA = 3'd4,
        CSUM = 3'd5,
        CLR  = 3'd6
    } state_t;

    // First byte of every frame
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Histogram sizes shared with the photon counter
    localparam int NBINS_DEF = 8;
    localparam int NIPI_DEF  = 64;

endpackage

// File: rtl/hist_frame_ser.sv
// Frame byte multiplexer and running XOR checksum.
// tx_data is built only from registered state, so it holds while stalled.
module hist_frame_ser
    import hist_readout_pkg::*;
(
    input  logic        clk,
    input  state_t      state,
    input  logic        accept,
    input  logic        xfer,
    input  logic [7:0]  flag,
    input  logic [7:0]  len,
    input  logic [31:0] word,
    input  logic [1:0]  byte_idx,
    output logic [7:0]  data
);

    logic [7:0] csum;
    logic [7:0] word_byte;

    // Pick the current byte of the current word, LSB first
    always_comb begin
        word_byte = word[7:0];
        case (byte_idx)
            2'd0: word_byte = word[7:0];
            2'd1: word_byte = word[15:8];
            2'd2: word_byte = word[23:16];
            2'd3: word_byte = word[31:24];
            default: word_byte = word[7:0];
        endcase
    end

    // Byte presented on the stream for each FSM state; zero when idle
    always_comb begin
        data = 8'h00;
        case (state)
            HDR:     data = SYNC_BYTE;
            FLAG:    data = flag;
            LEN:     data = len;
            DATA:    data = word_byte;
            CSUM:    data = csum;
            default: data = 8'h00;
        endcase
    end

    // Accumulate XOR over flag, length and data bytes as they transfer
    always_ff @(posedge clk) begin
        if (accept) begin
            csum <= 8'h00;
        end else if (xfer && (state == FLAG || state == LEN || state == DATA)) begin
            csum <= csum ^ data;
        end
    end

endmodule

// File: rtl/hist_readout.sv
// Histogram readout: snapshots the histo or ipihist array on a start
// request and streams it as a framed, checksummed byte stream.
module hist_readout
    import hist_readout_pkg::*;
#(
    parameter int NBINS = NBINS_DEF,
    parameter int NIPI  = NIPI_DEF
) (
    input  logic                   read_clk,
    input  logic                   reset,
    input  logic [NBINS-1:0][31:0] histo,
    input  logic [NIPI-1:0][31:0]  ipihist,
    input  logic                   collision,
    input  logic                   start,
    input  logic                   sel,
    input  logic                   clear_after,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic                   resethist_out
);

    localparam int MAXN = (NBINS > NIPI) ? NBINS : NIPI;
    localparam int IW   = (MAXN > 1) ? $clog2(MAXN) : 1;
    localparam logic [7:0] NBINS_LEN = 8'(NBINS);
    localparam logic [7:0] NIPI_LEN  = 8'(NIPI);

    // The length byte is 8 bits wide, so larger histograms cannot be framed
    if (NBINS < 1 || NBINS > 255 || NIPI < 1 || NIPI > 255) begin : g_bad_size
        $error("hist_readout: NBINS and NIPI must be in 1..255");
    end

    state_t                 state;
    logic                   sel_q;
    logic                   clear_q;
    logic                   coll_q;
    logic                   sticky;
    logic [1:0]             byte_idx;
    logic [IW-1:0]          word_idx;
    logic [MAXN-1:0][31:0]  snap;
    logic [MAXN-1:0][31:0]  histo_w;
    logic [MAXN-1:0][31:0]  ipi_w;
    logic [7:0]             len;
    logic                   accept;
    logic                   xfer;
    logic                   last_word;

    // Zero-extend both source arrays to a common depth for the snapshot
    for (genvar g = 0; g < MAXN; g++) begin : g_widen
        if (g < NBINS) begin : g_h
            assign histo_w[g] = histo[g];
        end else begin : g_hz
            assign histo_w[g] = '0;
        end
        if (g < NIPI) begin : g_i
            assign ipi_w[g] = ipihist[g];
        end else begin : g_iz
            assign ipi_w[g] = '0;
        end
    end

    assign accept    = (state == IDLE) && start && !reset;
    assign xfer      = tx_valid && tx_ready;
    assign len       = sel_q ? NIPI_LEN : NBINS_LEN;
    assign last_word = (word_idx == IW'(len - 8'd1));

    // Snapshot the selected histogram in the accept cycle
    always_ff @(posedge read_clk) begin
        if (accept) begin
            snap <= sel ? ipi_w : histo_w;
        end
    end

    // Readout FSM with registered stream and handshake outputs
    always_ff @(posedge read_clk) begin
        if (reset) begin
            state         <= IDLE;
            tx_valid      <= 1'b0;
            busy          <= 1'b0;
            resethist_out <= 1'b0;
            sticky        <= 1'b0;
            coll_q        <= 1'b0;
            sel_q         <= 1'b0;
            clear_q       <= 1'b0;
            byte_idx      <= 2'd0;
            word_idx      <= '0;
        end else begin
            resethist_out <= 1'b0;
            // A collision in the accept cycle is reported now and also kept
            // for the next frame
            if (accept) begin
                coll_q <= sticky | collision;
                sticky <= collision;
            end else begin
                sticky <= sticky | collision;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= HDR;
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        sel_q    <= sel;
                        clear_q  <= clear_after;
                        byte_idx <= 2'd0;
                        word_idx <= '0;
                    end
                end
                HDR:  if (xfer) state <= FLAG;
                FLAG: if (xfer) state <= LEN;
                LEN:  if (xfer) state <= DATA;
                DATA: begin
                    if (xfer) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            if (last_word) begin
                                state <= CSUM;
                            end else begin
                                word_idx <= word_idx + 1'b1;
                            end
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        tx_valid <= 1'b0;
                        if (clear_q) begin
                            state         <= CLR;
                            resethist_out <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                CLR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    hist_frame_ser u_ser (
        .clk      (read_clk),
        .state    (state),
        .accept   (accept),
        .xfer     (xfer),
        .flag     ({6'b0, coll_q, sel_q}),
        .len      (len),
        .word     (snap[word_idx]),
        .byte_idx (byte_idx),
        .data     (tx_data)
    );

endmodule
